syn_ram_arb: RTL
================

Name: syn_ram_arb

Overview:
- Two-port arbiter and sequencer for the single-port 32x8 synchronous RAM (syn_ram).
- Two requesters share the RAM; at most one access (read or write) is issued per clock.
- Round-robin arbitration, with an optional burst lock so one requester keeps the RAM for up to MAX_BURST consecutive beats.
- Sits between client logic and the syn_ram instance, driving its din/addr/w_en and consuming its dout.

Parameters:
- DATA_W, 8, data width; matches the RAM word.
- ADDR_W, 5, address width (32 locations).
- MAX_BURST, 4, max consecutive beats granted to a locked owner; legal range 1..15.

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- req0  in  1  port 0 access request; held until gnt0
- we0  in  1  port 0: 1=write, 0=read
- addr0  in  ADDR_W  port 0 address
- wdata0  in  DATA_W  port 0 write data
- lock0  in  1  port 0 requests burst ownership
- gnt0  out  1  port 0 access accepted this cycle
- rvalid0  out  1  port 0 read data valid
- rdata0  out  DATA_W  port 0 read data
- req1, we1, addr1, wdata1, lock1, gnt1, rvalid1, rdata1: same as port 0, for port 1
- ram_din  out  DATA_W  to RAM din
- ram_addr  out  ADDR_W  to RAM addr
- ram_w_en  out  1  to RAM w_en
- ram_dout  in  DATA_W  from RAM dout; registered, valid 1 cycle after read address

Behaviour:
- Registered state:
  - prio: 0/1, the port favoured on contention.
  - owner: NONE/P0/P1.
  - beat_cnt: 4 bits.
  - rd_pend0/rd_pend1.
- Reset (rst=1 at an edge):
  - prio=0, owner=NONE, beat_cnt=0, rd_pend=0.
  - While rst is high: gnt0/gnt1=0, ram_w_en=0, ram_addr=0, ram_din=0, rvalid0/rvalid1=0.
  - rdata outputs are unqualified when rvalid is low.
- Grant decision (combinational, every cycle):
  - If owner=Pn, req_n=1, lock_n=1 and beat_cnt<MAX_BURST: grant n (burst continue).
  - Otherwise, only one req high: grant that port.
  - Otherwise, both high: grant the port given by prio.
  - Otherwise: no grant.
- Granted cycle:
  - gnt_n=1.
  - ram_addr=addr_n, ram_w_en=we_n, ram_din=wdata_n.
- No-grant cycle:
  - ram_w_en=0.
  - ram_addr/ram_din hold their last driven values; no spurious writes.
- At most one of gnt0/gnt1 is high in any cycle. A request is accepted exactly in the cycle gnt is high. Requester may change req/addr/data the following cycle.
- Updates on the edge ending a granted cycle (port n):
  - prio = other port.
  - If lock_n=1: owner=Pn. If owner was already Pn, beat_cnt=beat_cnt+1, else beat_cnt=1.
  - If lock_n=0: owner=NONE, beat_cnt=0.
- Updates on the edge ending a no-grant cycle: owner=NONE, beat_cnt=0.
- Burst expiry: when beat_cnt=MAX_BURST the owner loses priority. Normal arbitration applies the same cycle, with no bubble. If the other port requests, it wins because prio already points to it.
- Read latency:
  - A read granted in cycle T sets rd_pend_n.
  - rvalid_n=1 in cycle T+1 with rdata_n=ram_dout.
  - rdata_n is driven from ram_dout at all times.
- Back-to-back reads by one port: rvalid_n is high on consecutive cycles.
- Write then read of the same address in consecutive cycles: the read returns the new data.
- Writes produce no rvalid.
- Reset asserted mid-burst or with a read pending: the pending rvalid is dropped and ownership is cleared.

Optional Feature:
- Macro: SYN_RAM_ARB_FIXED_PRI_EN.
- Defined:
  - Port 0 always wins contention; prio is not used.
  - Burst lock applies to port 0 only; lock1 is ignored and owner never becomes P1.
- Undefined: round-robin and lock on both ports, as described in Behaviour.

Test Plan:
- Single write then read: port 0 writes 10 to addr 1 (gnt0 same cycle, ram_w_en=1), then reads addr 1 -> rvalid0=1 one cycle later with rdata0=10; port 1 stays idle with gnt1=0.
- Contention after reset: both ports write (port 0: addr 2 = 25; port 1: addr 3 = 12) -> gnt0 in cycle 1, gnt1 in cycle 2; reads return 25 and 12.
- Round-robin fairness: both ports hold reads continuously for 8 cycles with lock low -> grants alternate 0,1,0,1…; each port sees 4 rvalid pulses.
- Burst lock: port 0 locked with 6 reads pending and port 1 requesting, MAX_BURST=4 -> gnt0 for 4 cycles, then gnt1, then gnt0.
- Mid-burst reset: rst asserted during the 2nd beat of a port 1 locked read burst -> no rvalid1 the next cycle; ram_w_en=0; the first grant after reset goes to port 0 under contention.
- With SYN_RAM_ARB_FIXED_PRI_EN defined: both ports request continuously with lock low -> gnt0 every cycle, gnt1 never.

Source files
------------

// File: rtl/syn_ram_arb.sv
// Two-port round-robin arbiter/sequencer with burst lock for the 32x8 syn_ram.
// Define SYN_RAM_ARB_FIXED_PRI_EN for fixed port-0 priority with port-0-only burst lock.
module syn_ram_arb #(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned ADDR_W    = 5,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    input  logic              lock0,
    output logic              gnt0,
    output logic              rvalid0,
    output logic [DATA_W-1:0] rdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    input  logic              lock1,
    output logic              gnt1,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata1,
    output logic [DATA_W-1:0] ram_din,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_w_en,
    input  logic [DATA_W-1:0] ram_dout
);
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_P0   = 2'd1,
        OWN_P1   = 2'd2
    } owner_t;

    localparam logic [3:0] BURST_LIM = 4'(MAX_BURST);

    owner_t            owner, owner_nx;
    logic [3:0]        beat_cnt, beat_nx, beat_inc;
    logic              rd_pend0, rd_pend1;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] din_q;
    logic              cont0, cont1, lk1;
`ifndef SYN_RAM_ARB_FIXED_PRI_EN
    logic              prio, prio_nx;
    assign lk1 = lock1;
`else
    assign lk1 = 1'b0;
`endif

    // Saturate so a long-held lock cannot wrap back into burst-continue range
    assign beat_inc = (beat_cnt == 4'hF) ? beat_cnt : beat_cnt + 4'd1;

    always_comb begin
        gnt0     = 1'b0;
        gnt1     = 1'b0;
        owner_nx = OWN_NONE;
        beat_nx  = '0;
`ifndef SYN_RAM_ARB_FIXED_PRI_EN
        prio_nx  = prio;
`endif
        cont0 = (owner == OWN_P0) && req0 && lock0 && (beat_cnt < BURST_LIM);
        cont1 = (owner == OWN_P1) && req1 && lk1   && (beat_cnt < BURST_LIM);

        if (!rst) begin
            if (cont0)              gnt0 = 1'b1;
            else if (cont1)         gnt1 = 1'b1;
            else if (req0 && req1) begin
`ifdef SYN_RAM_ARB_FIXED_PRI_EN
                gnt0 = 1'b1;
`else
                if (prio) gnt1 = 1'b1;
                else      gnt0 = 1'b1;
`endif
            end
            else if (req0)          gnt0 = 1'b1;
            else if (req1)          gnt1 = 1'b1;
        end

        if (gnt0) begin
`ifndef SYN_RAM_ARB_FIXED_PRI_EN
            prio_nx = 1'b1;
`endif
            if (lock0) begin
                owner_nx = OWN_P0;
                beat_nx  = (owner == OWN_P0) ? beat_inc : 4'd1;
            end
        end else if (gnt1) begin
`ifndef SYN_RAM_ARB_FIXED_PRI_EN
            prio_nx = 1'b0;
`endif
            if (lk1) begin
                owner_nx = OWN_P1;
                beat_nx  = (owner == OWN_P1) ? beat_inc : 4'd1;
            end
        end

        ram_w_en = (gnt0 & we0) | (gnt1 & we1);
        if (rst) begin
            ram_addr = '0;
            ram_din  = '0;
        end else if (gnt0) begin
            ram_addr = addr0;
            ram_din  = wdata0;
        end else if (gnt1) begin
            ram_addr = addr1;
            ram_din  = wdata1;
        end else begin
            ram_addr = addr_q;
            ram_din  = din_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            owner    <= OWN_NONE;
            beat_cnt <= '0;
            rd_pend0 <= 1'b0;
            rd_pend1 <= 1'b0;
            addr_q   <= '0;
            din_q    <= '0;
`ifndef SYN_RAM_ARB_FIXED_PRI_EN
            prio     <= 1'b0;
`endif
        end else begin
            owner    <= owner_nx;
            beat_cnt <= beat_nx;
            rd_pend0 <= gnt0 & ~we0;
            rd_pend1 <= gnt1 & ~we1;
            addr_q   <= ram_addr;
            din_q    <= ram_din;
`ifndef SYN_RAM_ARB_FIXED_PRI_EN
            prio     <= prio_nx;
`endif
        end
    end

    // A read pending across a reset edge must not surface while rst is held
    assign rvalid0 = rd_pend0 & ~rst;
    assign rvalid1 = rd_pend1 & ~rst;
    assign rdata0  = ram_dout;
    assign rdata1  = ram_dout;

endmodule
